alu_regfile: RTL and testbench

- Execution stage directly downstream of the instruction decoder. Consumes the 19-bit ALU control code every clock.
- Holds the architectural registers A–F, SS and SP, plus a flag register.
- Performs single-cycle ALU operations and write-back, and drives register contents onto the data path for store/write-back cycles.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_core.sv | 73 +++++++
 rtl/alu_regfile.sv | 98 +++++++++
 tb/tb_alu_regfile.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, register selectors, control-word fields and flag positions
package alu_pkg;

    localparam logic [7:0] OP_LOAD = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_NOT  = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_RAND = 8'h07;
    localparam logic [7:0] OP_ROR  = 8'h08;
    localparam logic [7:0] OP_MOV  = 8'hFF;

    localparam logic [3:0] REG_A   = 4'h0;
    localparam logic [3:0] REG_B   = 4'h1;
    localparam logic [3:0] REG_C   = 4'h2;
    localparam logic [3:0] REG_D   = 4'h3;
    localparam logic [3:0] REG_E   = 4'h4;
    localparam logic [3:0] REG_F   = 4'h5;
    localparam logic [3:0] REG_SS  = 4'h6;
    localparam logic [3:0] REG_SP  = 4'h7;
    localparam logic [3:0] SEL_IMM = 4'hF;

    localparam int CW_DIR      = 18;
    localparam int CW_EN       = 17;
    localparam int CW_IMM      = 16;
    localparam int CW_SEL1_LSB = 12;
    localparam int CW_SEL2_LSB = 8;
    localparam int CW_OP_LSB   = 0;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    // Ops that never look at the second operand leave sel2 unchecked.
    function automatic logic op_uses_b(input logic [7:0] op);
        return !(op == OP_LOAD || op == OP_NOT || op == OP_RAND);
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result, next flags and undefined-op detection
module alu_core
    import alu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] lfsr,
    input  logic [7:0]    op,
    input  logic [3:0]    flags_in,
    output logic [DW-1:0] result,
    output logic [3:0]    flags_out,
    output logic          illegal
);

    localparam int SW = $clog2(DW) + 1;

    logic [DW:0]   sum_ext;
    logic [DW-1:0] diff;
    logic [DW-1:0] rot;
    logic [SW-1:0] sh;
    logic          c;
    logic          v;
    logic          upd_zn;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign diff    = a - b;
    assign sh      = SW'(b[3:0]);
    assign rot     = (a >> sh) | (a << (SW'(DW) - sh));

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        upd_zn  = 1'b1;
        c       = flags_in[FLAG_C];
        v       = flags_in[FLAG_V];
        case (op)
            OP_LOAD: begin result = d; upd_zn = 1'b0; end
            OP_ADD: begin
                result = sum_ext[DW-1:0];
                c      = sum_ext[DW];
                v      = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            OP_SUB: begin
                result = diff;
                c      = (a < b);
                v      = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
            end
            OP_AND:  begin result = a & b; c = 1'b0; v = 1'b0; end
            OP_OR:   begin result = a | b; c = 1'b0; v = 1'b0; end
            OP_XOR:  begin result = a ^ b; c = 1'b0; v = 1'b0; end
            OP_NOT:  result = ~a;
            OP_RAND: result = lfsr;
            OP_ROR: begin
                result = rot;
                // The last bit rotated out lands in the MSB of the result.
                c      = (sh != '0) ? rot[DW-1] : 1'b0;
            end
            OP_MOV:  begin result = b; upd_zn = 1'b0; end
            default: begin illegal = 1'b1; upd_zn = 1'b0; end
        endcase
        flags_out         = flags_in;
        flags_out[FLAG_C] = c;
        flags_out[FLAG_V] = v;
        if (upd_zn) begin
            flags_out[FLAG_N] = result[DW-1];
            flags_out[FLAG_Z] = (result == '0);
        end
    end

endmodule

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - execution stage: register file, flags, LFSR, read-out and accept logic
module alu_regfile
    import alu_pkg::*;
#(
    parameter int          DW        = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [18:0]   i_alu_control_code,
    input  logic          i_hold,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          o_data_valid,
    output logic [3:0]    o_flags,
    output logic [DW-1:0] o_sp,
    output logic          o_err
);

    logic [DW-1:0] regs [8];
    logic [15:0]   lfsr;
    logic          lfsr_fb;

    logic          dir;
    logic          imm;
    logic [3:0]    sel1;
    logic [3:0]    sel2;
    logic [7:0]    op;
    logic          accept;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [DW-1:0] result;
    logic [3:0]    flags_next;
    logic          op_illegal;
    logic          bad_read;
    logic          bad_write;

    assign dir    = i_alu_control_code[CW_DIR];
    assign imm    = i_alu_control_code[CW_IMM];
    assign sel1   = i_alu_control_code[CW_SEL1_LSB +: 4];
    assign sel2   = i_alu_control_code[CW_SEL2_LSB +: 4];
    assign op     = i_alu_control_code[CW_OP_LSB +: 8];
    assign accept = i_alu_control_code[CW_EN] && !i_hold;

    assign opa = regs[sel1[2:0]];
    assign opb = (imm || sel2 == SEL_IMM) ? i_data : regs[sel2[2:0]];

    // Reads accept SEL_IMM as a pass-through; writes need a real destination.
    assign bad_read  = sel1[3] && (sel1 != SEL_IMM);
    assign bad_write = sel1[3] || op_illegal
                    || (op_uses_b(op) && sel2[3] && (sel2 != SEL_IMM));

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign o_sp    = regs[REG_SP[2:0]];

    alu_core #(.DW(DW)) u_core (
        .a         (opa),
        .b         (opb),
        .d         (i_data),
        .lfsr      (DW'(lfsr)),
        .op        (op),
        .flags_in  (o_flags),
        .result    (result),
        .flags_out (flags_next),
        .illegal   (op_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            o_flags      <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_err        <= 1'b0;
            lfsr         <= LFSR_SEED;
        end else begin
            lfsr         <= {lfsr_fb, lfsr[15:1]};
            o_data_valid <= 1'b0;
            o_err        <= 1'b0;
            if (accept) begin
                if (dir) begin
                    if (bad_read) begin
                        o_err <= 1'b1;
                    end else begin
                        o_data       <= (sel1 == SEL_IMM) ? i_data : opa;
                        o_data_valid <= 1'b1;
                    end
                end else if (bad_write) begin
                    o_err <= 1'b1;
                end else begin
                    regs[sel1[2:0]] <= result;
                    o_flags         <= flags_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_regfile.sv
// tb/tb_alu_regfile.sv - directed self-checking bench for alu_regfile
module tb_alu_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] cw;
    logic        hold;
    logic [15:0] din;
    logic [15:0] o_data;
    logic        o_data_valid;
    logic [3:0]  o_flags;
    logic [15:0] o_sp;
    logic        o_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] m_lfsr;
    logic [15:0] exp_rand;

    always #5 clk = ~clk;

    alu_regfile #(.DW(16), .LFSR_SEED(16'hACE1)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_alu_control_code (cw),
        .i_hold             (hold),
        .i_data             (din),
        .o_data             (o_data),
        .o_data_valid       (o_data_valid),
        .o_flags            (o_flags),
        .o_sp               (o_sp),
        .o_err              (o_err)
    );

    // Reference Fibonacci LFSR, taps 16,14,13,11.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= (m_lfsr >> 1) | ((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h1) << 15);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] w(input logic d, input logic i, input logic [3:0] s1,
                                      input logic [3:0] s2, input logic [7:0] op);
        return {d, 1'b1, i, s1, s2, op};
    endfunction

    task automatic step(input logic [18:0] c, input logic [15:0] d);
        cw  = c;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [3:0] s, input logic [15:0] exp);
        step(w(1, 0, s, 0, 8'h00), 16'h0);
        chk({tag, "_valid"}, o_data_valid, 1);
        chk(tag, o_data, exp);
    endtask

    initial begin
        rst = 1'b1; cw = '0; hold = 1'b0; din = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_data_valid, 0);
        chk("rst_flags", o_flags, 0);
        chk("rst_err", o_err, 0);
        chk("rst_sp", o_sp, 0);

        step(w(0, 0, 0, 0, 8'h00), 16'h1234);
        chk("load_err", o_err, 0);
        step(w(1, 0, 0, 0, 8'h00), 16'h0);
        chk("read1_valid", o_data_valid, 1);
        chk("read1_data", o_data, 16'h1234);
        chk("read1_flags", o_flags, 0);
        step('0, 16'h0);
        chk("read1_valid_drop", o_data_valid, 0);
        chk("read1_hold", o_data, 16'h1234);
        step(w(1, 0, 4'hF, 0, 8'h00), 16'hBEEF);
        chk("pass_data", o_data, 16'hBEEF);

        step(w(0, 0, 0, 0, 8'h00), 16'hFFFF);
        step(w(0, 0, 1, 0, 8'h00), 16'h0001);
        step(w(0, 0, 0, 1, 8'h01), 16'h0);
        chk("add_flags", o_flags, 4'b0011);
        rd("add_res", 0, 16'h0000);
        step(w(0, 0, 0, 1, 8'h02), 16'h0);
        chk("sub_flags", o_flags, 4'b1010);
        rd("sub_res", 0, 16'hFFFF);

        step(w(0, 0, 0, 0, 8'h00), 16'h7FFF);
        step(w(0, 1, 0, 0, 8'h01), 16'h0001);
        chk("addi_flags", o_flags, 4'b1100);
        step(w(0, 0, 2, 0, 8'hFF), 16'h0);
        chk("mov_flags", o_flags, 4'b1100);
        rd("mov_res", 2, 16'h8000);

        step(w(0, 0, 7, 0, 8'h00), 16'h0100);
        chk("sp_out", o_sp, 16'h0100);

        step(w(0, 0, 0, 0, 8'h00), 16'h8001);
        step(w(0, 1, 0, 0, 8'h08), 16'h0001);
        chk("ror1_nzc", o_flags & 4'b1011, 4'b1010);
        rd("ror1_res", 0, 16'hC000);
        step(w(0, 1, 0, 0, 8'h08), 16'h0000);
        chk("ror0_nzc", o_flags & 4'b1011, 4'b1000);
        rd("ror0_res", 0, 16'hC000);
        step(w(0, 0, 0, 0, 8'h06), 16'h0);
        chk("xor_flags", o_flags, 4'b0001);
        rd("xor_res", 0, 16'h0000);

        rst = 1'b1;
        step('0, 16'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step('0, 16'h0);
        exp_rand = m_lfsr;
        step(w(0, 0, 3, 0, 8'h07), 16'h0);
        rd("rand_res", 3, exp_rand);
        chk("rand_nz", o_data != 16'h0, 1);

        step(w(0, 0, 0, 0, 8'h00), 16'h1111);
        step(w(0, 0, 1, 0, 8'h00), 16'h2222);
        step(w(0, 0, 0, 1, 8'h02), 16'h0);
        chk("sub2_flags", o_flags, 4'b1010);
        step(w(0, 0, 4'h9, 0, 8'h00), 16'h5555);
        chk("sel9_err", o_err, 1);
        step('0, 16'h0);
        chk("err_pulse", o_err, 0);
        step(w(0, 0, 0, 1, 8'h42), 16'h0);
        chk("op42_err", o_err, 1);
        chk("op42_flags", o_flags, 4'b1010);
        step(w(0, 0, 4'hF, 0, 8'h00), 16'h5555);
        chk("self_err", o_err, 1);
        step(w(0, 0, 0, 4'hA, 8'h01), 16'h0);
        chk("sel2a_err", o_err, 1);
        step(w(1, 0, 4'hB, 0, 8'h00), 16'h0);
        chk("badrd_err", o_err, 1);
        chk("badrd_valid", o_data_valid, 0);
        rd("err_a", 0, 16'hEEEF);
        rd("err_b", 1, 16'h2222);
        chk("err_flags", o_flags, 4'b1010);

        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(w(0, 0, 0, 1, 8'h01), 16'h0);
            chk("hold_flags", o_flags, 4'b1010);
            chk("hold_err", o_err, 0);
        end
        hold = 1'b0;
        rd("hold_a", 0, 16'hEEEF);

        step(w(0, 0, 7, 0, 8'h00), 16'h0200);
        rst = 1'b1;
        step(w(1, 0, 0, 0, 8'h00), 16'h0);
        rst = 1'b0;
        chk("mrst_valid", o_data_valid, 0);
        chk("mrst_data", o_data, 0);
        chk("mrst_flags", o_flags, 0);
        chk("mrst_sp", o_sp, 0);
        rd("mrst_a", 0, 16'h0);
        rd("mrst_b", 1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
